vec_alu_seq: RTL and testbench
==============================

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, vector operand/result width; legal values 32, 64, 128.
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN/8)+1, lane counter width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  000 VADD, 001 VSUB, 010 VMUL, 011 VMACC, 100 VDOT; others illegal.
REQ-008 sew  input  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 illegal.
REQ-009 opA, opB, opC  input  XLEN each  source vectors; element i occupies bits [i*SEW +: SEW].
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 alu_out  output  XLEN  result vector.
REQ-013 err  output  1  result came from an illegal op/sew; qualified by out_valid.

Function
REQ-014 Lane count L = XLEN/SEW.
REQ-015 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs when in_valid && in_ready. On accept, op/sew/opA/opB/opC SHALL be captured; later input changes SHALL be ignored.
REQ-018 Legal accept: IDLE->EXEC, lane counter = 0, result register cleared.
REQ-019 EXEC SHALL process exactly one element per cycle, lane 0 first, using a single SEW-wide datapath.
REQ-020 Lane results, all mod 2^SEW:
- VADD: a+b
- VSUB: a-b
- VMUL: low SEW bits of a*b
- VMACC: a*b+c
REQ-021 VDOT: (sum over all lanes of a*b) + c[0], mod 2^SEW. The sum SHALL be placed in element 0; all other bits SHALL be 0.
REQ-022 After lane L-1, the FSM SHALL enter DONE. Accept at cycle 0 gives out_valid=1 at cycle L+1.
REQ-023 In DONE, out_valid=1 and alu_out/err SHALL be held stable until out_ready=1.
REQ-024 DONE with out_ready=1 SHALL return to IDLE next cycle. Back-to-back throughput is one request per L+2 cycles.
REQ-025 out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
REQ-026 Illegal op or sew at accept: IDLE->DONE directly, alu_out=0, err=1, out_valid at cycle 1.
REQ-027 out_valid SHALL be 0 in IDLE and EXEC. alu_out SHALL never show partial results while out_valid=0.

Reset
REQ-028 reset=1 SHALL force, at the next edge: IDLE, counter=0, out_valid=0, alu_out=0, err=0, in_ready=1.
REQ-029 reset asserted during EXEC or DONE SHALL abort the operation with no result delivered; reset has priority over all handshakes.

Structure
REQ-030 Package vec_alu_pkg SHALL hold the op encodings, sew encodings, state enum and a function sew_bits(sew).
REQ-031 Sub-module vec_lane_mac SHALL implement the combinational 32-bit lane datapath (add/sub/mul/mac, masked to SEW). The FSM, operand registers and result assembly SHALL remain in vec_alu_seq.

Verification
REQ-032 VMACC, sew=10, XLEN=32, A=B=0x00001111, C=0x22221111 -> alu_out=0x23455432, err=0, out_valid at cycle 2.
REQ-033 VADD and VMUL, sew=00:
- VADD, A=B=0x04030201 -> 0x08060402, out_valid at cycle 5.
- VMUL, A=B=0x0C0B0A09 -> 0x90796451.
REQ-034 VDOT, sew=00, XLEN=64:
- A=B=0x0101010101010101, C=0x05 -> 0x000000000000000D at cycle 9.
- VSUB, sew=00, A=0x00, B=0x01 -> element 0 = 0xFF (wrap).
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in DONE -> alu_out stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
REQ-036 Illegal and reset cases:
- sew=11 -> err=1, alu_out=0 at cycle 1.
- op=111 -> same response.
- reset during EXEC of VDOT -> out_valid never asserts, in_ready=1 after the reset edge.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared encodings and element-width helpers for the sequential vector ALU.
package vec_alu_pkg;

    typedef enum logic [2:0] {
        OP_VADD  = 3'b000,
        OP_VSUB  = 3'b001,
        OP_VMUL  = 3'b010,
        OP_VMACC = 3'b011,
        OP_VDOT  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        SEW_8   = 2'b00,
        SEW_16  = 2'b01,
        SEW_32  = 2'b10,
        SEW_BAD = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    function automatic logic [5:0] sew_bits(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 6'd8;
            SEW_16:  return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [2:0] sew_lg2(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 3'd3;
            SEW_16:  return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [31:0] sew_mask(input logic [1:0] sew);
        case (sew_bits(sew))
            6'd8:    return 32'h0000_00FF;
            6'd16:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] op, input logic [1:0] sew);
        return (op <= 3'b100) && (sew != SEW_BAD);
    endfunction

endpackage

// File: rtl/vec_alu_seq_lane.sv
// Combinational single-element datapath; result is truncated to the element width.
module vec_lane_mac
    import vec_alu_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  sew_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    output logic [31:0] y_o
);

    logic [31:0] prod;
    logic [31:0] raw;

    always_comb begin
        prod = a_i * b_i;
        case (op_i)
            OP_VADD: raw = a_i + b_i;
            OP_VSUB: raw = a_i - b_i;
            OP_VMUL: raw = prod;
            default: raw = prod + c_i;  // VMACC, and VDOT with c as running sum
        endcase
        y_o = raw & sew_mask(sew_i);
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Sequential vector ALU: one element per cycle through a single lane datapath.
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN/8) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [1:0]      sew,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [XLEN-1:0] opC,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            err
);

    state_e            state_q;
    op_e               op_q;
    logic [1:0]        sew_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   a_q, b_q, c_q, res_q, alu_out_q;
    logic              out_valid_q, err_q;

    logic [7:0]        offs;
    logic [31:0]       msk, lane_a, lane_b, lane_c, lane_y;
    logic [XLEN-1:0]   res_d;
    logic [CNT_W-1:0]  last_cnt;

    always_comb begin
        msk      = sew_mask(sew_q);
        offs     = 8'(cnt_q) << sew_lg2(sew_q);
        lane_a   = 32'(a_q >> offs) & msk;
        lane_b   = 32'(b_q >> offs) & msk;
        // VDOT threads its accumulator through the c input, seeded by element 0 of C
        if (op_q == OP_VDOT)
            lane_c = ((cnt_q == '0) ? c_q[31:0] : res_q[31:0]) & msk;
        else
            lane_c = 32'(c_q >> offs) & msk;
        res_d    = (op_q == OP_VDOT) ? XLEN'(lane_y) : (res_q | (XLEN'(lane_y) << offs));
        last_cnt = CNT_W'((XLEN >> sew_lg2(sew_q)) - 1);
    end

    vec_lane_mac u_lane (
        .op_i  (op_q),
        .sew_i (sew_q),
        .a_i   (lane_a),
        .b_i   (lane_b),
        .c_i   (lane_c),
        .y_o   (lane_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_q  <= op_e'(op);
                    sew_q <= sew;
                    a_q   <= opA;
                    b_q   <= opB;
                    c_q   <= opC;
                    cnt_q <= '0;
                    res_q <= '0;
                    if (is_legal(op, sew)) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        alu_out_q   <= '0;
                    end
                end
                S_EXEC: begin
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == last_cnt) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b0;
                        alu_out_q   <= res_d;
                    end
                end
                S_DONE: if (out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    alu_out_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: XLEN=32 and XLEN=64 instances behind a select, scoreboard-checked.
module tb_vec_alu_seq;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, sel;
    logic [2:0]  op;
    logic [1:0]  sew;
    logic [63:0] opA, opB, opC;
    logic        rdy32, rdy64, ov32, ov64, err32, err64;
    logic [31:0] out32;
    logic [63:0] out64;
    logic        iv32, iv64, in_ready, out_valid, err;
    logic [63:0] alu_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int   acc_q[$];
    int   lane_q[$];

    assign iv32      = in_valid & ~sel;
    assign iv64      = in_valid &  sel;
    assign in_ready  = sel ? rdy64 : rdy32;
    assign out_valid = sel ? ov64  : ov32;
    assign err       = sel ? err64 : err32;
    assign alu_out   = sel ? out64 : {32'b0, out32};

    vec_alu_seq #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32),
        .op(op), .sew(sew), .opA(opA[31:0]), .opB(opB[31:0]), .opC(opC[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .alu_out(out32), .err(err32)
    );

    vec_alu_seq #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(rdy64),
        .op(op), .sew(sew), .opA(opA), .opB(opB), .opC(opC),
        .out_valid(ov64), .out_ready(out_ready), .alu_out(out64), .err(err64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [1:0] s,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input int xlen,
                                          output logic e_err, output int lanes);
        int w;
        logic [63:0] m, r, ea, eb, ec, e, acc;
        e_err = (o > 3'd4) || (s == 2'b11);
        lanes = 0;
        if (e_err) return 64'd0;
        w     = 8 << s;
        lanes = xlen / w;
        m     = (64'd1 << w) - 64'd1;
        r     = 64'd0;
        acc   = c & m;
        for (int i = 0; i < lanes; i++) begin
            ea = (a >> (i * w)) & m;
            eb = (b >> (i * w)) & m;
            ec = (c >> (i * w)) & m;
            case (o)
                3'd0:    e = ea + eb;
                3'd1:    e = ea - eb;
                3'd2:    e = ea * eb;
                3'd3:    e = ea * eb + ec;
                default: begin acc = acc + ea * eb; e = 64'd0; end
            endcase
            r = r | ((e & m) << (i * w));
        end
        if (o == 3'd4) r = acc & m;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait for acceptance, push the expectation.
    task automatic issue(input logic [2:0] o, input logic [1:0] s,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t x;
        logic e_err;
        int   l;
        x.res = model(o, s, a, b, c, sel ? 64 : 32, e_err, l);
        x.err = e_err;
        x.lat = l + 1;
        op = o; sew = s; opA = a; opB = b; opC = c; in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++) tick();
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL issue_wait: in_ready=%0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        sb.push_back(x);
        acc_q.push_back(cyc);
        lane_q.push_back(l);
    endtask

    // Wait for out_valid; lat counts cycles after the accept edge (1 = right after it).
    task automatic collect(output logic [63:0] r, output logic e, output int lat, output bit to);
        lat = 1;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        to = !out_valid;
        r  = alu_out;
        e  = err;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, in_ready); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid sel=%0d: got %b want 0", s, out_valid); end
            tests++; if (alu_out !== 64'd0)  begin fails++; $display("FAIL reset_alu_out sel=%0d: got %h want 0", s, alu_out); end
            tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err sel=%0d: got %b want 0", s, err); end
        end
        sel = 1'b0;
    endtask

    // Directed vectors with known results: {sel, op, sew, A, B, C, result, err, cycle}.
    task automatic test_directed();
        logic        t_sel[7];
        logic [2:0]  t_op[7];
        logic [1:0]  t_sew[7];
        logic [63:0] t_a[7], t_b[7], t_c[7], t_res[7];
        logic        t_err[7];
        int          t_cyc[7];
        logic [63:0] r;
        logic        e;
        int          lat;
        bit          to;
        exp_t        x;
        t_sel = '{0, 0, 0, 1, 1, 0, 0};
        t_op  = '{3'd3, 3'd0, 3'd2, 3'd4, 3'd1, 3'd0, 3'd7};
        t_sew = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        t_a   = '{64'h1111, 64'h04030201, 64'h0C0B0A09, 64'h0101010101010101, 64'h0, 64'h12345678, 64'h12345678};
        t_b   = '{64'h1111, 64'h04030201, 64'h0C0B0A09, 64'h0101010101010101, 64'h1, 64'h11111111, 64'h11111111};
        t_c   = '{64'h22221111, 64'h0, 64'h0, 64'h5, 64'h0, 64'h0, 64'h0};
        t_res = '{64'h23455432, 64'h08060402, 64'h90796451, 64'hD, 64'hFF, 64'h0, 64'h0};
        t_err = '{0, 0, 0, 0, 0, 1, 1};
        t_cyc = '{2, 5, 5, 9, 9, 1, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sel = t_sel[i];
            issue(t_op[i], t_sew[i], t_a[i], t_b[i], t_c[i]);
            collect(r, e, lat, to);
            x = sb.pop_front();
            tests++; if (to)               begin fails++; $display("FAIL dir%0d_timeout: no out_valid", i); end
            tests++; if (r !== t_res[i])   begin fails++; $display("FAIL dir%0d_data: got %h want %h", i, r, t_res[i]); end
            tests++; if (r !== x.res)      begin fails++; $display("FAIL dir%0d_model: got %h want %h", i, r, x.res); end
            tests++; if (e !== t_err[i])   begin fails++; $display("FAIL dir%0d_err: got %b want %b", i, e, t_err[i]); end
            tests++; if (lat != t_cyc[i])  begin fails++; $display("FAIL dir%0d_cycle: got %0d want %0d", i, lat, t_cyc[i]); end
            tick();
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] r0;
        logic        e;
        int          lat;
        bit          to;
        exp_t        x;
        sel = 1'b0; out_ready = 1'b0;
        issue(3'd0, 2'd0, 64'h04030201, 64'h10203040, 64'h0);
        collect(r0, e, lat, to);
        x = sb.pop_front();
        tests++; if (r0 !== x.res) begin fails++; $display("FAIL bp_data: got %h want %h", r0, x.res); end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; op = 3'd1; opA = {$urandom, $urandom};
            tick();
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid%0d: got %b want 1", k, out_valid); end
            tests++; if (alu_out !== r0)     begin fails++; $display("FAIL bp_hold_data%0d: got %h want %h", k, alu_out, r0); end
            tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_exec();
        bit seen = 0;
        sel = 1'b1; out_ready = 1'b1;
        issue(3'd4, 2'd0, 64'h0101010101010101, 64'h0101010101010101, 64'h5);
        void'(sb.pop_front());
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_exec_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 20; k++) begin
            if (out_valid) seen = 1;
            tick();
        end
        tests++; if (seen) begin fails++; $display("FAIL rst_exec_no_result: out_valid seen=%0b want 0", seen); end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        sel = 1'b1; out_ready = 1'b1;
        acc_q.delete(); lane_q.delete();
        fork
            for (int i = 0; i < N; i++)
                issue(3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            for (int i = 0; i < N; i++) begin
                logic [63:0] r;
                logic        e;
                int          lat;
                bit          to;
                exp_t        x;
                collect(r, e, lat, to);
                tests++;
                if (to || sb.size() == 0) begin
                    fails++; $display("FAIL b2b%0d_timeout: valid=%b queued=%0d", i, out_valid, sb.size());
                end else begin
                    x = sb.pop_front();
                    if (r !== x.res || e !== x.err) begin
                        fails++; $display("FAIL b2b%0d_data: got %h/%b want %h/%b", i, r, e, x.res, x.err);
                    end
                end
                tick();
            end
        join
        for (int i = 1; i < N; i++) begin
            tests++;
            if (acc_q[i] - acc_q[i-1] != lane_q[i-1] + 2) begin
                fails++; $display("FAIL b2b%0d_spacing: got %0d want %0d", i, acc_q[i] - acc_q[i-1], lane_q[i-1] + 2);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; sew = '0; opA = '0; opB = '0; opC = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
